// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one registered multiplier among NREQ requesters.
// Results are returned tagged with the owning requester index.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_x,
  input  logic [16*NREQ-1:0] req_y,
  output logic [15:0]        mul_x,
  output logic [15:0]        mul_y,
  input  logic [31:0]        mul_p,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [31:0]        resp_p,
  output logic               busy,
  output logic [15:0]        done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] gnt_inc;
  logic [IDW-1:0] idx;
  logic           any_vld;
  logic           accept;
  logic [2:0]     wait_cnt;
  logic [15:0]    sel_x;
  logic [15:0]    sel_y;

  // first valid requester at or after rr_ptr, with wrap
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_ptr) + 32'(k)) % 32'(NREQ));
      if (!any_vld && req_valid[idx]) begin
        any_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign gnt_inc = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == gnt) begin
        sel_x = req_x[16*k +: 16];
        sel_y = req_y[16*k +: 16];
      end
    end
  end

  assign accept = (state == IDLE) && any_vld;

  always_comb begin
    req_ready = '0;
    if (accept && rst)
      req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    resp_valid = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (wait_cnt == '0)
          state_nxt = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      mul_x    <= '0;
      mul_y    <= '0;
      resp_id  <= '0;
      resp_p   <= '0;
      wait_cnt <= '0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        mul_x    <= sel_x;
        mul_y    <= sel_y;
        resp_id  <= gnt;
        rr_ptr   <= gnt_inc;
        wait_cnt <= 3'(MUL_LAT);
      end
      if (state == WAIT) begin
        if (wait_cnt != '0)
          wait_cnt <= wait_cnt - 1'b1;
        else
          resp_p <= mul_p;
      end
      if (state == RESP && resp_ready)
        done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed scenarios plus a randomized
// transaction-level reference model.
module tb_mul_share_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  rv, rdy;
  logic [16*N-1:0] rx, ry;
  logic [15:0]   mx, my, dc;
  logic [31:0]   mp, rp;
  logic          rsv, rr, bsy;
  logic [1:0]    rid;

  logic [N-1:0]  rv3, rdy3;
  logic [16*N-1:0] rx3, ry3;
  logic [15:0]   mx3, my3, dc3;
  logic [31:0]   mp3, rp3, s1, s2;
  logic          rsv3, rr3, bsy3;
  logic [1:0]    rid3;

  int total = 0;
  int bad = 0;
  int grants[$];
  int accs[$];

  mul_share_arbiter #(.NREQ(4), .IDW(2), .MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rdy),
    .req_x(rx), .req_y(ry), .mul_x(mx), .mul_y(my), .mul_p(mp),
    .resp_valid(rsv), .resp_ready(rr), .resp_id(rid), .resp_p(rp),
    .busy(bsy), .done_cnt(dc));

  mul_share_arbiter #(.NREQ(4), .IDW(2), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rdy3),
    .req_x(rx3), .req_y(ry3), .mul_x(mx3), .mul_y(my3), .mul_p(mp3),
    .resp_valid(rsv3), .resp_ready(rr3), .resp_id(rid3), .resp_p(rp3),
    .busy(bsy3), .done_cnt(dc3));

  // exact multiplier stubs: 1-cycle and 3-cycle registered
  always_ff @(posedge clk)
    mp <= {{16{mx[15]}}, mx} * {{16{my[15]}}, my};

  always_ff @(posedge clk) begin
    s1  <= {{16{mx3[15]}}, mx3} * {{16{my3[15]}}, my3};
    s2  <= s1;
    mp3 <= s2;
  end

  function automatic int prod(shortint a, shortint b);
    return int'(a) * int'(b);
  endfunction

  function automatic int first_from(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b0;
    rv = '0;
    rr = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rv = 4'hF; rx = {$urandom, $urandom}; ry = {$urandom, $urandom}; rr = 1'b1;
    rv3 = 4'hF; rx3 = '0; ry3 = '0; rr3 = 1'b1;
    #2;
    total++;
    if ({rdy, mx, my, rsv, rid, rp, bsy, dc} !== '0) begin
      bad++;
      $display("FAIL reset_main got=%h exp=0", {rdy, mx, my, rsv, rid, rp, bsy, dc});
    end
    total++;
    if ({rdy3, mx3, my3, rsv3, rid3, rp3, bsy3, dc3} !== '0) begin
      bad++;
      $display("FAIL reset_lat3 got=%h exp=0", {rdy3, mx3, my3, rsv3, rid3, rp3, bsy3, dc3});
    end
    tick();
    rv = '0; rv3 = '0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    int n = 0;
    tick();
    rv = 4'b0100; rx[47:32] = 16'd3; ry[47:32] = 16'd5; rr = 1'b1;
    #1;
    total++;
    if (rdy !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", rdy); end
    do begin tick(); rv = '0; #1; n++; end while (!rsv && n < 20);
    total++;
    if (n != 3) begin bad++; $display("FAIL single_latency got=%0d exp=3", n); end
    total++;
    if (rid !== 2'd2 || rp !== prod(3, 5)) begin
      bad++; $display("FAIL single_resp got id=%0d p=%h exp id=2 p=%h", rid, rp, prod(3, 5));
    end
    tick(); #1;
    total++;
    if (dc !== 16'd1 || bsy !== 1'b0) begin
      bad++; $display("FAIL single_done got cnt=%0d busy=%b exp cnt=1 busy=0", dc, bsy);
    end
  endtask

  task automatic test_signed();
    int n = 0;
    tick();
    rv = 4'b0001; rx[15:0] = 16'hFFFE; ry[15:0] = 16'd7;
    #1;
    total++;
    if (rdy !== 4'b0001) begin bad++; $display("FAIL signed_ready got=%b exp=0001", rdy); end
    do begin tick(); rv = '0; #1; n++; end while (!rsv && n < 20);
    total++;
    if (n != 3 || rid !== 2'd0 || rp !== prod(-2, 7)) begin
      bad++; $display("FAIL signed_resp got n=%0d id=%0d p=%h exp n=3 id=0 p=%h", n, rid, rp, prod(-2, 7));
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n = 0;
    int ep;
    tick();
    rr = 1'b0;
    rv = 4'b1000; rx[63:48] = 16'($urandom); ry[63:48] = 16'($urandom);
    ep = prod(rx[63:48], ry[63:48]);
    #1;
    total++;
    if (rdy !== 4'b1000) begin bad++; $display("FAIL bp_ready got=%b exp=1000", rdy); end
    do begin tick(); rv = 4'b0111; #1; n++; end while (!rsv && n < 20);
    for (int i = 0; i < 5; i++) begin
      tick(); rx = {$urandom, $urandom}; ry = {$urandom, $urandom}; #1;
      total++;
      if (rsv !== 1'b1 || rid !== 2'd3 || rp !== ep || rdy !== '0) begin
        bad++;
        $display("FAIL bp_hold got v=%b id=%0d p=%h rdy=%b exp v=1 id=3 p=%h rdy=0", rsv, rid, rp, rdy, ep);
      end
    end
    tick(); rr = 1'b1; #1;
    tick(); #1;
    total++;
    if (rsv !== 1'b0 || rdy !== 4'b0001) begin
      bad++; $display("FAIL bp_regrant got v=%b rdy=%b exp v=0 rdy=0001", rsv, rdy);
    end
    n = 0;
    do begin tick(); rv = '0; #1; n++; end while (!rsv && n < 20);
    tick(); #1;
    total++;
    if (dc !== 16'd4) begin bad++; $display("FAIL bp_done got=%0d exp=4", dc); end
  endtask

  task automatic test_mul_lat3();
    int n = 0;
    tick();
    rr3 = 1'b1; rv3 = 4'b0001; rx3[15:0] = 16'd100; ry3[15:0] = 16'hFF9C;
    #1;
    total++;
    if (rdy3 !== 4'b0001) begin bad++; $display("FAIL lat3_ready got=%b exp=0001", rdy3); end
    do begin
      tick(); rv3 = '0; rx3 = {$urandom, $urandom}; ry3 = {$urandom, $urandom}; #1; n++;
      if (!rsv3 && bsy3) begin
        total++;
        if (mx3 !== 16'd100 || my3 !== 16'hFF9C) begin
          bad++; $display("FAIL lat3_hold got x=%h y=%h exp x=0064 y=ff9c", mx3, my3);
        end
      end
    end while (!rsv3 && n < 20);
    total++;
    if (n != 5 || rp3 !== prod(100, -100)) begin
      bad++; $display("FAIL lat3_resp got n=%0d p=%h exp n=5 p=%h", n, rp3, prod(100, -100));
    end
    tick();
  endtask

  task automatic test_reset_wait();
    int n = 0;
    int ep;
    tick();
    rv = 4'b0010; rx[31:16] = 16'($urandom); ry[31:16] = 16'($urandom);
    ep = prod(rx[31:16], ry[31:16]);
    #1;
    total++;
    if (rdy !== 4'b0010) begin bad++; $display("FAIL rw_ready got=%b exp=0010", rdy); end
    tick(); #1;
    rst = 1'b0;
    #1;
    total++;
    if ({rdy, mx, my, rsv, rid, rp, bsy, dc} !== '0) begin
      bad++; $display("FAIL rw_outputs got=%h exp=0", {rdy, mx, my, rsv, rid, rp, bsy, dc});
    end
    tick(); rst = 1'b1; #1;
    total++;
    if (rdy !== 4'b0010 || rsv !== 1'b0 || dc !== 16'd0) begin
      bad++; $display("FAIL rw_regrant got rdy=%b v=%b cnt=%0d exp rdy=0010 v=0 cnt=0", rdy, rsv, dc);
    end
    do begin tick(); rv = '0; #1; n++; end while (!rsv && n < 20);
    total++;
    if (n != 3 || rid !== 2'd1 || rp !== ep) begin
      bad++; $display("FAIL rw_resp got n=%0d id=%0d p=%h exp n=3 id=1 p=%h", n, rid, rp, ep);
    end
    tick(); #1;
    total++;
    if (dc !== 16'd1) begin bad++; $display("FAIL rw_done got=%0d exp=1", dc); end
  endtask

  // transaction-level model: one outstanding job, response 3 cycles after accept
  task automatic run_model(int cycles, bit allv);
    int ptr = 0, age = 0, done = 0, g, eid = 0, ep = 0;
    bit mb = 1'b0;
    logic [3:0] er;
    grants.delete();
    accs.delete();
    for (int c = 0; c < cycles; c++) begin
      tick();
      rv = allv ? 4'hF : 4'($urandom);
      rr = allv ? 1'b1 : ($urandom_range(0, 3) != 0);
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      #1;
      er = '0;
      g = -1;
      if (!mb) begin
        g = first_from(rv, ptr);
        if (g >= 0) er[g] = 1'b1;
      end
      total++;
      if (rdy !== er) begin bad++; $display("FAIL model_ready c=%0d got=%b exp=%b", c, rdy, er); end
      total++;
      if (rsv !== (mb && age >= 3) || bsy !== mb) begin
        bad++; $display("FAIL model_state c=%0d got v=%b busy=%b exp v=%b busy=%b", c, rsv, bsy, mb && age >= 3, mb);
      end
      if (mb && age >= 3) begin
        total++;
        if (rid !== eid[1:0] || rp !== ep) begin
          bad++; $display("FAIL model_resp c=%0d got id=%0d p=%h exp id=%0d p=%h", c, rid, rp, eid, ep);
        end
      end
      total++;
      if (dc !== 16'(done)) begin bad++; $display("FAIL model_done c=%0d got=%0d exp=%0d", c, dc, done); end
      if (mb && age >= 3 && rr) begin
        mb = 1'b0;
        done++;
      end else if (mb) begin
        age++;
      end else if (g >= 0) begin
        mb = 1'b1;
        age = 1;
        eid = g;
        ep = prod(rx[16*g +: 16], ry[16*g +: 16]);
        ptr = (g + 1) % 4;
        grants.push_back(g);
        accs.push_back(c);
      end
    end
  endtask

  task automatic test_rotate();
    pulse_reset();
    run_model(30, 1'b1);
    total++;
    if (grants.size() < 5) begin
      bad++; $display("FAIL rotate_count got=%0d exp>=5", grants.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (grants[i] != i % 4) begin
          bad++; $display("FAIL rotate_order i=%0d got=%0d exp=%0d", i, grants[i], i % 4);
        end
        if (i > 0) begin
          total++;
          if (accs[i] - accs[i-1] != 4) begin
            bad++; $display("FAIL rotate_interval i=%0d got=%0d exp=4", i, accs[i] - accs[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    pulse_reset();
    run_model(600, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_backpressure();
    test_mul_lat3();
    test_reset_wait();
    test_rotate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
